// File: rtl/cnt_seq_ctrl_if.sv
// Host/counter-side signal bundle for the interval sequencer.
interface cnt_seq_ctrl_if #(
  parameter int unsigned W     = 32,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = $clog2(DEPTH)
);
  // Table programming
  logic          tbl_we_i;
  logic [AW-1:0] tbl_addr_i;
  logic [W-1:0]  tbl_wdata_i;
  logic          tbl_err_o;
  // Sequence control / status
  logic [AW:0]   num_steps_i;
  logic          repeat_i;
  logic          start_i;
  logic          stop_i;
  logic          busy_o;
  logic [AW-1:0] step_idx_o;
  logic          step_done_o;
  logic          seq_done_o;
  // Counter control
  logic          cnt_en_o;
  logic          cnt_clr_o;
  logic [W-1:0]  cnt_thr_o;
  logic          cnt_tc_i;

  // Host / counter side
  modport master (
    output tbl_we_i, tbl_addr_i, tbl_wdata_i, num_steps_i, repeat_i,
           start_i, stop_i, cnt_tc_i,
    input  tbl_err_o, busy_o, step_idx_o, step_done_o, seq_done_o,
           cnt_en_o, cnt_clr_o, cnt_thr_o
  );

  // Sequencer side
  modport slave (
    input  tbl_we_i, tbl_addr_i, tbl_wdata_i, num_steps_i, repeat_i,
           start_i, stop_i, cnt_tc_i,
    output tbl_err_o, busy_o, step_idx_o, step_done_o, seq_done_o,
           cnt_en_o, cnt_clr_o, cnt_thr_o
  );
endinterface

// File: rtl/cnt_seq_ctrl.sv
// Interval sequencer: walks a programmed threshold table, driving a simple
// counter's enable/clear/threshold and reporting step and sequence completion.
module cnt_seq_ctrl #(
  parameter int unsigned W     = 32,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input logic           clk_i,
  input logic           rst_ni,
  cnt_seq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_e;

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  state_e        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [AW:0]   nsteps_q, nsteps_d;
  logic          rpt_q, rpt_d;
  logic [W-1:0]  thr_q, thr_d;
  logic          err_q;
  logic [W-1:0]  tbl_q [DEPTH];

  logic en_c, clr_c, step_c, seq_c;
  logic adv, load;
  logic start_ok, last_step, wr_ok;

  // Start needs a legal entry count and no concurrent stop
  assign start_ok  = bus.start_i && !bus.stop_i && (bus.num_steps_i != '0) &&
                     (bus.num_steps_i <= DEPTH_L);
  assign last_step = ((AW+1)'(idx_q) + (AW+1)'(1)) == nsteps_q;
  assign wr_ok     = (state_q == IDLE) && ((AW+1)'(bus.tbl_addr_i) < DEPTH_L);

  // Next-state, index/threshold update and same-cycle counter controls
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    nsteps_d = nsteps_q;
    rpt_d    = rpt_q;
    thr_d    = thr_q;
    en_c     = 1'b0;
    clr_c    = 1'b0;
    step_c   = 1'b0;
    seq_c    = 1'b0;
    adv      = 1'b0;
    load     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_ok) begin
          nsteps_d = bus.num_steps_i;
          rpt_d    = bus.repeat_i;
          idx_d    = '0;
          state_d  = LOAD;
          load     = 1'b1;
        end
      end
      LOAD: begin
        clr_c = 1'b1;
        if (bus.stop_i) begin
          state_d = IDLE;
        end else if (thr_q == '0) begin
          // zero-length interval: report it and move on without running
          step_c = 1'b1;
          adv    = 1'b1;
        end else begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (bus.stop_i) begin
          clr_c   = 1'b1;
          state_d = IDLE;
        end else begin
          en_c = 1'b1;
          if (bus.cnt_tc_i) begin
            step_c = 1'b1;
            adv    = 1'b1;
          end
        end
      end
      DONE: begin
        clr_c   = 1'b1;
        state_d = IDLE;
        if (!bus.stop_i) seq_c = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (adv) begin
      if (!last_step) begin
        idx_d   = idx_q + AW'(1);
        state_d = LOAD;
        load    = 1'b1;
      end else if (rpt_q) begin
        idx_d   = '0;
        state_d = LOAD;
        load    = 1'b1;
      end else begin
        state_d = DONE;
      end
    end

    if (load) thr_d = tbl_q[idx_d];

    // Reset suppresses completion pulses in the cycle it is applied
    if (!rst_ni) begin
      step_c = 1'b0;
      seq_c  = 1'b0;
    end
  end

  // Control state registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      nsteps_q <= '0;
      rpt_q    <= 1'b0;
      thr_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      nsteps_q <= nsteps_d;
      rpt_q    <= rpt_d;
      thr_q    <= thr_d;
      err_q    <= bus.tbl_we_i && !wr_ok;
    end
  end

  // Interval table; writes only land while idle and in range
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) tbl_q[i] <= '0;
    end else if (bus.tbl_we_i && wr_ok) begin
      tbl_q[bus.tbl_addr_i] <= bus.tbl_wdata_i;
    end
  end

  assign bus.tbl_err_o   = err_q;
  assign bus.busy_o      = (state_q != IDLE);
  assign bus.step_idx_o  = idx_q;
  assign bus.cnt_thr_o   = thr_q;
  assign bus.cnt_en_o    = en_c;
  assign bus.cnt_clr_o   = clr_c;
  assign bus.step_done_o = step_c;
  assign bus.seq_done_o  = seq_c;

endmodule

// File: tb/tb_cnt_seq_ctrl.sv
// Bench for cnt_seq_ctrl: directed runs with a counter model on the tc input
// and queued expectations for step/sequence/error pulses.
module tb_cnt_seq_ctrl;

  localparam int unsigned W     = 16;
  localparam int unsigned DEPTH = 6;
  localparam int unsigned AW    = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic tc_force;
  logic [W-1:0] cnt_m;
  int cyc = 0;
  int total = 0;
  int bad = 0;

  typedef struct {int idx; int cyc;} ev_t;
  ev_t step_q[$];
  int  seq_q[$];
  int  err_q[$];
  ev_t ev;
  int  ecyc;

  cnt_seq_ctrl_if #(.W(W), .DEPTH(DEPTH), .AW(AW)) bus ();

  cnt_seq_ctrl #(.W(W), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Simple counter: counts from 0 while enabled, tc when it reaches thr
  assign bus.cnt_tc_i = (bus.cnt_en_o && (cnt_m == bus.cnt_thr_o)) || tc_force;
  always @(posedge clk) begin
    if (!rst_n || bus.cnt_clr_o) cnt_m <= '0;
    else if (bus.cnt_en_o) cnt_m <= (cnt_m == bus.cnt_thr_o) ? '0 : cnt_m + W'(1);
  end

  // Monitor: pop and compare on each pulse; flag expectations that went by
  always @(negedge clk) begin
    if (bus.step_done_o) begin
      total++;
      if (step_q.size() == 0) begin
        bad++;
        $display("FAIL step_unexpected: got pulse idx=%0d at cyc=%0d, required none", bus.step_idx_o, cyc);
      end else begin
        ev = step_q.pop_front();
        if (ev.cyc != cyc || ev.idx != int'(bus.step_idx_o)) begin
          bad++;
          $display("FAIL step: got idx=%0d cyc=%0d, required idx=%0d cyc=%0d", bus.step_idx_o, cyc, ev.idx, ev.cyc);
        end
      end
    end
    while (step_q.size() > 0 && step_q[0].cyc < cyc) begin
      total++; bad++;
      $display("FAIL step_missed: got no pulse, required idx=%0d cyc=%0d", step_q[0].idx, step_q[0].cyc);
      void'(step_q.pop_front());
    end
    if (bus.seq_done_o) begin
      total++;
      if (seq_q.size() == 0) begin
        bad++;
        $display("FAIL seq_unexpected: got pulse at cyc=%0d, required none", cyc);
      end else begin
        ecyc = seq_q.pop_front();
        if (ecyc != cyc) begin
          bad++;
          $display("FAIL seq: got cyc=%0d, required cyc=%0d", cyc, ecyc);
        end
      end
    end
    while (seq_q.size() > 0 && seq_q[0] < cyc) begin
      total++; bad++;
      $display("FAIL seq_missed: got no pulse, required cyc=%0d", seq_q[0]);
      void'(seq_q.pop_front());
    end
    if (bus.tbl_err_o) begin
      total++;
      if (err_q.size() == 0) begin
        bad++;
        $display("FAIL err_unexpected: got pulse at cyc=%0d, required none", cyc);
      end else begin
        ecyc = err_q.pop_front();
        if (ecyc != cyc) begin
          bad++;
          $display("FAIL err: got cyc=%0d, required cyc=%0d", cyc, ecyc);
        end
      end
    end
    while (err_q.size() > 0 && err_q[0] < cyc) begin
      total++; bad++;
      $display("FAIL err_missed: got no pulse, required cyc=%0d", err_q[0]);
      void'(err_q.pop_front());
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk); #1;
  endtask

  task automatic goto(input int t);
    while (cyc < t) next_cyc();
  endtask

  task automatic at_neg(input int t);
    goto(t);
    @(negedge clk);
  endtask

  task automatic wr(input int a, input int d);
    bus.tbl_we_i    = 1'b1;
    bus.tbl_addr_i  = AW'(a);
    bus.tbl_wdata_i = W'(d);
    next_cyc();
    bus.tbl_we_i    = 1'b0;
  endtask

  task automatic start(input int n, input bit r, output int s);
    s = cyc;
    bus.num_steps_i = (AW+1)'(n);
    bus.repeat_i    = r;
    bus.start_i     = 1'b1;
    next_cyc();
    bus.start_i     = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, int'(bus.busy_o), 0);
    chk({tag, "_idx"},  int'(bus.step_idx_o), 0);
    chk({tag, "_thr"},  int'(bus.cnt_thr_o), 0);
    chk({tag, "_en"},   int'(bus.cnt_en_o), 0);
    chk({tag, "_clr"},  int'(bus.cnt_clr_o), 0);
    chk({tag, "_step"}, int'(bus.step_done_o), 0);
    chk({tag, "_seq"},  int'(bus.seq_done_o), 0);
    chk({tag, "_err"},  int'(bus.tbl_err_o), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required test completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    rst_n = 1'b0; tc_force = 1'b0;
    bus.tbl_we_i = 1'b0; bus.tbl_addr_i = '0; bus.tbl_wdata_i = '0;
    bus.num_steps_i = '0; bus.repeat_i = 1'b0; bus.start_i = 1'b0; bus.stop_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk_zero("reset");

    // Two-step one-shot run {3,1}
    wr(0, 3);
    wr(1, 1);
    @(negedge clk);
    chk("wr_ok_err", int'(bus.tbl_err_o), 0);
    start(2, 1'b0, s);
    step_q.push_back('{idx: 0, cyc: s + 5});
    step_q.push_back('{idx: 1, cyc: s + 8});
    seq_q.push_back(s + 9);
    at_neg(s + 1);
    chk("load_clr", int'(bus.cnt_clr_o), 1);
    chk("load_en", int'(bus.cnt_en_o), 0);
    chk("load_thr", int'(bus.cnt_thr_o), 3);
    chk("load_busy", int'(bus.busy_o), 1);
    at_neg(s + 2);
    chk("run_en", int'(bus.cnt_en_o), 1);
    at_neg(s + 9);
    chk("done_busy", int'(bus.busy_o), 1);
    at_neg(s + 10);
    chk("post_busy", int'(bus.busy_o), 0);
    chk("post_idx_hold", int'(bus.step_idx_o), 1);

    // Zero entry skipped in LOAD: {2,0,2}
    wr(0, 2); wr(1, 0); wr(2, 2);
    start(3, 1'b0, s);
    step_q.push_back('{idx: 0, cyc: s + 4});
    step_q.push_back('{idx: 1, cyc: s + 5});
    step_q.push_back('{idx: 2, cyc: s + 9});
    seq_q.push_back(s + 10);
    at_neg(s + 5);
    chk("skip_en", int'(bus.cnt_en_o), 0);
    chk("skip_clr", int'(bus.cnt_clr_o), 1);
    at_neg(s + 11);
    chk("skip_post_busy", int'(bus.busy_o), 0);

    // Repeating {1,1}, then stop
    wr(0, 1); wr(1, 1);
    start(2, 1'b1, s);
    for (int k = 0; k < 7; k++) step_q.push_back('{idx: k % 2, cyc: s + 3 + 3 * k});
    at_neg(s + 22);
    chk("rpt_idx", int'(bus.step_idx_o), 1);
    goto(s + 23);
    bus.stop_i = 1'b1;
    @(negedge clk);
    chk("stop_clr", int'(bus.cnt_clr_o), 1);
    chk("stop_en", int'(bus.cnt_en_o), 0);
    next_cyc();
    bus.stop_i = 1'b0;
    @(negedge clk);
    chk("stop_busy", int'(bus.busy_o), 0);

    // Stop coinciding with tc: no step pulse
    wr(0, 2);
    start(1, 1'b0, s);
    goto(s + 4);
    bus.stop_i = 1'b1; tc_force = 1'b1;
    @(negedge clk);
    chk("stop_tc_step", int'(bus.step_done_o), 0);
    next_cyc();
    bus.stop_i = 1'b0; tc_force = 1'b0;
    @(negedge clk);
    chk("stop_tc_busy", int'(bus.busy_o), 0);

    // Write while busy and out-of-range write are rejected
    start(1, 1'b0, s);
    step_q.push_back('{idx: 0, cyc: s + 4});
    seq_q.push_back(s + 5);
    goto(s + 2);
    err_q.push_back(s + 3);
    wr(0, 9);
    goto(s + 7);
    err_q.push_back(cyc + 1);
    wr(6, 7);
    start(1, 1'b0, s);
    step_q.push_back('{idx: 0, cyc: s + 4});
    seq_q.push_back(s + 5);
    at_neg(s + 1);
    chk("readback_thr", int'(bus.cnt_thr_o), 2);
    goto(s + 7);

    // Illegal starts are ignored
    start(0, 1'b0, s);
    at_neg(s + 1);
    chk("nsteps0_busy", int'(bus.busy_o), 0);
    start(7, 1'b0, s);
    at_neg(s + 1);
    chk("nsteps7_busy", int'(bus.busy_o), 0);
    bus.stop_i = 1'b1;
    start(2, 1'b0, s);
    bus.stop_i = 1'b0;
    at_neg(s + 1);
    chk("start_stop_busy", int'(bus.busy_o), 0);

    // Reset mid-RUN clears everything, table included
    wr(0, 5);
    start(1, 1'b0, s);
    goto(s + 3);
    rst_n = 1'b0;
    next_cyc();
    rst_n = 1'b1;
    @(negedge clk);
    chk_zero("midrst");
    start(1, 1'b0, s);
    step_q.push_back('{idx: 0, cyc: s + 1});
    seq_q.push_back(s + 2);
    at_neg(s + 1);
    chk("rst_tbl_en", int'(bus.cnt_en_o), 0);
    goto(s + 5);

    @(negedge clk);
    chk("sb_drain", step_q.size() + seq_q.size() + err_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cnt_seq_ctrl.md
Name: cnt_seq_ctrl

Overview:
- Sequencer that drives the simple counter's control inputs (enable, clear, threshold) through a programmed table of intervals.
- Interval i runs for thr[i] counter ticks. Each completed interval raises a step event; the end of the table raises a sequence event. Optionally the table repeats.
- Sits between the counter control registers / host configuration and the counter instance, replacing direct software sequencing of consecutive timer periods.

Parameters:
- W, 32, counter/threshold width (1..32)
- DEPTH, 8, number of interval table entries (2..16)
- AW, $clog2(DEPTH), table index width

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- tbl_we_i  in  1  table write strobe
- tbl_addr_i  in  AW  table write index
- tbl_wdata_i  in  W  interval threshold to store
- tbl_err_o  out  1  pulse: write rejected (busy, or addr >= DEPTH)
- num_steps_i  in  AW+1  entries used, sampled on start
- repeat_i  in  1  loop the table forever, sampled on start
- start_i  in  1  start sequence (level sampled in IDLE)
- stop_i  in  1  abort sequence
- busy_o  out  1  sequence active
- step_idx_o  out  AW  current table index
- step_done_o  out  1  pulse: interval finished
- seq_done_o  out  1  pulse: sequence finished (non-repeat only)
- cnt_en_o  out  1  counter enable
- cnt_clr_o  out  1  counter clear
- cnt_thr_o  out  W  counter threshold
- cnt_tc_i  in  1  counter terminal-count pulse (cnt == thr while enabled)

Behaviour:
- Reset (rst_ni low at a clk_i edge):
  - All outputs 0; state IDLE.
  - Table entries reset to 0.
  - Reset has priority over everything, including mid-sequence; no step or seq pulse is emitted on reset.
- Table writes:
  - Accepted only in IDLE with tbl_addr_i < DEPTH; the entry is written at the edge.
  - Otherwise the write is dropped and tbl_err_o pulses 1 cycle later for 1 cycle.
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE:
  - busy_o=0, cnt_en_o=0.
  - start_i=1 and num_steps_i in 1..DEPTH: latch num_steps and repeat, idx<=0, go to LOAD.
  - start_i with num_steps_i=0 or >DEPTH: ignored; stay IDLE, no pulse.
- LOAD (1 cycle):
  - cnt_clr_o=1, cnt_en_o=0, cnt_thr_o=table[idx].
  - If table[idx]==0 the step is skipped: step_done_o=1 this cycle, then advance (see advance rule).
  - Otherwise go to RUN.
- RUN:
  - cnt_en_o=1; cnt_thr_o holds table[idx] (registered, stable for the whole step).
  - On cnt_tc_i=1: step_done_o=1 in that same cycle (combinational from tc and state), cnt_en_o stays 1, then advance.
  - Step latency from LOAD entry to step_done_o is table[idx]+1 cycles for the counter, which counts from 0.
- Advance rule:
  - idx<num_steps-1: idx<=idx+1, go to LOAD.
  - Last step, repeat=1: idx<=0, go to LOAD.
  - Last step, repeat=0: go to DONE.
- DONE (1 cycle):
  - seq_done_o=1, cnt_clr_o=1, then IDLE.
  - step_idx_o holds the last index until the next start.
- busy_o = 1 in LOAD, RUN and DONE.
- stop_i:
  - In LOAD, RUN or DONE: next state IDLE. That cycle drives cnt_en_o=0 and cnt_clr_o=1.
  - No step_done_o or seq_done_o is emitted, even if cnt_tc_i coincides; stop wins.
  - In IDLE, stop_i has no effect.
  - stop_i together with start_i in IDLE: start ignored.
- Ignored inputs:
  - cnt_tc_i outside RUN is ignored.
  - start_i while busy is ignored; num_steps_i and repeat_i changes while busy have no effect.
- cnt_thr_o is registered and updated only on entering LOAD.

Test Plan:
- Reset then idle: all outputs 0; write table[0]=3 in IDLE -> accepted, tbl_err_o stays 0.
- Program {3,1}, num_steps=2, repeat=0, pulse start:
  - step_done_o at cycle 5 (idx 0) after start, then at cycle 8 (idx 1).
  - seq_done_o the following cycle; busy_o falls the cycle after.
- Program {2,0,2}, num_steps=3:
  - idx1 gives step_done_o during its LOAD cycle with no RUN cycles; cnt_en_o stays 0 that cycle.
  - Total of 3 step pulses, 1 seq pulse.
- repeat=1, num_steps=2, {1,1}:
  - idx sequence 0,1,0,1…; no seq_done_o over 20 cycles.
  - stop_i -> busy_o=0 next cycle, cnt_clr_o=1 on the stop cycle.
- stop_i asserted in the same cycle as cnt_tc_i in RUN -> no step_done_o, state IDLE.
- Error cases:
  - Write while busy, or tbl_addr_i=DEPTH -> tbl_err_o pulse, entry unchanged (readback via a later run).
  - start with num_steps=0 -> stays IDLE.
  - rst_ni low mid-RUN -> all outputs 0 next edge.
